// File: rtl/dct_block_scheduler.sv
// Ping-pong 8x8 block buffer and sequencer in front of dct_2d: replays each full block
// into the engine, tags the returning coefficients and guards against a hung engine.
module dct_block_scheduler #(
    parameter int PIX_W   = 8,
    parameter int COEF_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [PIX_W-1:0]         s_pixel,
    output logic                     dct_start,
    output logic [PIX_W-1:0]         dct_pixel,
    input  logic signed [COEF_W-1:0] dct_coeff,
    input  logic                     dct_valid,
    input  logic                     dct_done,
    output logic                     m_valid,
    output logic signed [COEF_W-1:0] m_coeff,
    output logic [5:0]               m_index,
    output logic                     m_last,
    output logic [15:0]              blk_count,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     proto_err,
    input  logic                     clr_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT} state_t;

    state_t                     state;
    logic [PIX_W-1:0]           pix_mem [0:127];
    logic [1:0]                 full;
    logic [1:0]                 full_nxt;
    logic                       fill_ptr;
    logic                       iss_ptr;
    logic [5:0]                 wr_cnt;
    logic [6:0]                 rd_cnt;
    logic [6:0]                 out_cnt;
    logic [TO_W-1:0]            to_cnt;
    logic                       accept;
    logic                       fill_done;
    logic                       release_blk;
    logic                       timed_out;
    logic                       coef_in;
    logic                       coef_keep;
    logic                       vld_p1;
    logic signed [COEF_W-1:0]   coef_p1;

    always_comb begin
        accept      = s_valid && s_ready;
        fill_done   = accept && (wr_cnt == 6'd63);
        timed_out   = (state == WAIT) && !dct_done && (to_cnt == TO_W'(TIMEOUT));
        release_blk = (state == WAIT) && (dct_done || (to_cnt == TO_W'(TIMEOUT)));
        coef_in     = dct_valid && ((state == FEED) || (state == WAIT));
        // out_cnt parks at 64 once the last coefficient is out; anything further is a protocol error
        coef_keep   = coef_in && (out_cnt != 7'd64);
        full_nxt    = full;
        if (release_blk)
            full_nxt[iss_ptr] = 1'b0;
        if (fill_done)
            full_nxt[fill_ptr] = 1'b1;
    end

    assign s_ready = !full[fill_ptr];
    assign busy    = (|full) || (state != IDLE);
    assign m_valid = vld_p1;
    assign m_coeff = coef_p1;

    always_ff @(posedge clk) begin
        if (accept)
            pix_mem[{fill_ptr, wr_cnt}] <= s_pixel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            full        <= 2'b00;
            fill_ptr    <= 1'b0;
            iss_ptr     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            to_cnt      <= '0;
            dct_start   <= 1'b0;
            dct_pixel   <= '0;
            vld_p1      <= 1'b0;
            coef_p1     <= '0;
            m_index     <= '0;
            m_last      <= 1'b0;
            blk_count   <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (fill_done)
                    fill_ptr <= ~fill_ptr;
            end

            // coefficient stage p0 -> p1
            vld_p1 <= coef_keep;
            m_last <= 1'b0;
            if (coef_keep) begin
                coef_p1 <= dct_coeff;
                m_index <= out_cnt[5:0];
                m_last  <= (out_cnt == 7'd63);
                out_cnt <= out_cnt + 7'd1;
                if (out_cnt == 7'd63)
                    blk_count <= blk_count + 16'd1;
            end

            if (timed_out)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
            if (coef_in && (out_cnt == 7'd64))
                proto_err <= 1'b1;
            else if (clr_err)
                proto_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (full[iss_ptr]) begin
                        state   <= FEED;
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                FEED: begin
                    if (rd_cnt == 7'd64) begin
                        dct_start <= 1'b0;
                        dct_pixel <= '0;
                        to_cnt    <= '0;
                        state     <= WAIT;
                    end else begin
                        dct_start <= 1'b1;
                        dct_pixel <= pix_mem[{iss_ptr, rd_cnt[5:0]}];
                        rd_cnt    <= rd_cnt + 7'd1;
                    end
                end
                WAIT: begin
                    if (release_blk) begin
                        state   <= IDLE;
                        iss_ptr <= ~iss_ptr;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Bench for dct_block_scheduler: directed scenarios with random pixels and coefficients,
// a reactive dct_2d model and queue-based expectations for pixels and coefficients.
module tb_dct_block_scheduler;

    localparam int PIX_W   = 8;
    localparam int COEF_W  = 16;
    localparam int TIMEOUT = 1024;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     s_valid = 1'b0;
    logic [PIX_W-1:0]         s_pixel = '0;
    logic                     clr_err = 1'b0;
    logic                     s_ready;
    logic                     dct_start;
    logic [PIX_W-1:0]         dct_pixel;
    logic signed [COEF_W-1:0] dct_coeff;
    logic                     dct_valid;
    logic                     dct_done;
    logic                     m_valid;
    logic signed [COEF_W-1:0] m_coeff;
    logic [5:0]               m_index;
    logic                     m_last;
    logic [15:0]              blk_count;
    logic                     busy;
    logic                     timeout_err;
    logic                     proto_err;

    typedef struct packed {
        logic [15:0] coef;
        logic [5:0]  idx;
    } exp_t;

    exp_t             exp_q[$];
    logic [PIX_W-1:0] exp_pix[$];
    int               total = 0;
    int               bad = 0;
    int               mon_cnt = 0;
    int               eng_delay = 5;
    int               eng_nvalid = 64;
    bit               eng_hang = 0;
    bit               eng_special = 0;
    bit               eng_abort = 0;
    int               eng_n;
    logic [15:0]      eng_c;
    exp_t             mon_e;
    int               w;
    logic [15:0]      b0;

    dct_block_scheduler #(.PIX_W(PIX_W), .COEF_W(COEF_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .dct_start(dct_start), .dct_pixel(dct_pixel), .dct_coeff(dct_coeff),
        .dct_valid(dct_valid), .dct_done(dct_done), .m_valid(m_valid), .m_coeff(m_coeff),
        .m_index(m_index), .m_last(m_last), .blk_count(blk_count), .busy(busy),
        .timeout_err(timeout_err), .proto_err(proto_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the pixel was accepted.
    task automatic send_pix(input logic [PIX_W-1:0] v);
        int t = 0;
        s_valid = 1'b1;
        s_pixel = v;
        while (!s_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        exp_pix.push_back(v);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int n);
        int t = 0;
        while ((busy || mon_cnt < n) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_out_cnt"}, mon_cnt, n);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    // Output monitor: every m_valid must match the next coefficient the engine produced.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                mon_cnt++;
                if (exp_q.size() == 0) begin
                    chk("m_valid_unexpected", {31'd0, m_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_coeff", {16'd0, m_coeff}, {16'd0, mon_e.coef});
                    chk("m_index", {26'd0, m_index}, {26'd0, mon_e.idx});
                    chk("m_last", {31'd0, m_last}, {31'd0, mon_e.idx == 6'd63});
                end
            end
        end
    end

    // dct_2d model: collect the start burst, then return eng_nvalid coefficients and done.
    initial begin : engine
        dct_valid = 1'b0;
        dct_coeff = '0;
        dct_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && dct_start) begin
                eng_n = 0;
                while (dct_start && eng_n < 100) begin
                    if (exp_pix.size() == 0)
                        chk("pix_unexpected", {31'd0, exp_pix.size() == 0}, 32'd0);
                    else
                        chk("dct_pixel", {24'd0, dct_pixel}, {24'd0, exp_pix.pop_front()});
                    eng_n++;
                    @(negedge clk);
                end
                if (!eng_abort) begin
                    chk("start_len", eng_n, 64);
                    repeat (eng_delay) @(negedge clk);
                    if (!eng_hang) begin
                        for (int k = 0; k < eng_nvalid; k++) begin
                            if (eng_special) begin
                                case (k % 3)
                                    0:       eng_c = 16'hFC00;
                                    1:       eng_c = 16'h7FFF;
                                    default: eng_c = 16'h8000;
                                endcase
                            end else begin
                                eng_c = 16'($urandom);
                            end
                            if (k < 64) exp_q.push_back('{eng_c, 6'(k)});
                            dct_valid = 1'b1;
                            dct_coeff = eng_c;
                            @(negedge clk);
                        end
                        dct_valid = 1'b0;
                        dct_done  = 1'b1;
                        @(negedge clk);
                        dct_done  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_dct_start", {31'd0, dct_start}, 32'd0);
        chk("rst_dct_pixel", {24'd0, dct_pixel}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_blk_count", {16'd0, blk_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_errs", {30'd0, timeout_err, proto_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset held 3 cycles in the middle of a FEED burst
        eng_abort = 1'b1;
        for (int i = 0; i < 64; i++) send_pix(PIX_W'($urandom));
        w = 0;
        while (!dct_start && w < 50) begin @(negedge clk); w++; end
        chk("t1_start_seen", {31'd0, dct_start}, 32'd1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t1_dct_start", {31'd0, dct_start}, 32'd0);
        chk("t1_s_ready", {31'd0, s_ready}, 32'd1);
        chk("t1_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t1_blk_count", {16'd0, blk_count}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pix.delete();
        exp_q.delete();
        @(negedge clk);
        eng_abort = 1'b0;

        // Single block with pixels 0..63, start latency of two cycles
        mon_cnt = 0;
        for (int i = 0; i < 64; i++) send_pix(PIX_W'(i));
        chk("t2_lat0", {31'd0, dct_start}, 32'd0);
        @(negedge clk);
        chk("t2_lat1", {31'd0, dct_start}, 32'd0);
        @(negedge clk);
        chk("t2_lat2", {31'd0, dct_start}, 32'd1);
        wait_idle("t2", 64);
        chk("t2_blk_count", {16'd0, blk_count}, 32'd1);

        // Three blocks back to back against a slow engine
        eng_delay = 150;
        mon_cnt = 0;
        b0 = blk_count;
        for (int i = 0; i < 192; i++) begin
            send_pix(PIX_W'($urandom));
            if (i == 127) begin
                chk("t3_ready_full", {31'd0, s_ready}, 32'd0);
                chk("t3_busy", {31'd0, busy}, 32'd1);
            end
        end
        wait_idle("t3", 192);
        chk("t3_blk_count", {16'd0, blk_count}, {16'd0, b0 + 16'd3});
        eng_delay = 5;

        // Hung engine: watchdog release, then a normal block, then clr_err
        eng_hang = 1'b1;
        mon_cnt = 0;
        b0 = blk_count;
        for (int i = 0; i < 64; i++) send_pix(PIX_W'($urandom));
        w = 0;
        while (!dct_start && w < 50) begin @(negedge clk); w++; end
        w = 0;
        while (dct_start && w < 100) begin @(negedge clk); w++; end
        chk("t4_feed_end", {31'd0, dct_start}, 32'd0);
        repeat (TIMEOUT) @(negedge clk);
        chk("t4_err_early", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        chk("t4_err_set", {31'd0, timeout_err}, 32'd1);
        chk("t4_released", {31'd0, busy}, 32'd0);
        eng_hang = 1'b0;
        for (int i = 0; i < 64; i++) send_pix(PIX_W'($urandom));
        wait_idle("t4", 64);
        chk("t4_blk_count", {16'd0, blk_count}, {16'd0, b0 + 16'd1});
        chk("t4_err_sticky", {31'd0, timeout_err}, 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_err_clr", {31'd0, timeout_err}, 32'd0);

        // 65 valids in one block
        eng_nvalid = 65;
        mon_cnt = 0;
        b0 = blk_count;
        for (int i = 0; i < 64; i++) send_pix(PIX_W'($urandom));
        wait_idle("t5", 64);
        chk("t5_proto_err", {31'd0, proto_err}, 32'd1);
        chk("t5_blk_count", {16'd0, blk_count}, {16'd0, b0 + 16'd1});
        eng_nvalid = 64;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t5_proto_clr", {31'd0, proto_err}, 32'd0);

        // Extreme signed coefficients
        eng_special = 1'b1;
        mon_cnt = 0;
        b0 = blk_count;
        for (int i = 0; i < 64; i++) send_pix(PIX_W'($urandom));
        wait_idle("t6", 64);
        chk("t6_blk_count", {16'd0, blk_count}, {16'd0, b0 + 16'd1});
        chk("t6_errs", {30'd0, timeout_err, proto_err}, 32'd0);
        eng_special = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
